// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin req/ack arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int ARB_N_CLIENTS      = 4;
    localparam int ARB_REQ_DATA_W     = 8;
    localparam int ARB_ACK_DATA_W     = 8;
    localparam int ARB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: the first set request bit found scanning
// upward from last_winner+1, wrapping around.
module rr_priority_picker #(
    parameter int N_CLIENTS = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic [N_CLIENTS-1:0] i_req,
    input  logic [ID_WIDTH-1:0]  i_last,
    output logic                 o_valid,
    output logic [ID_WIDTH-1:0]  o_id
);

    logic [ID_WIDTH-1:0] w_cand;

    // Scan farthest-to-nearest so the client closest after i_last wins.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        w_cand  = '0;
        for (int k = N_CLIENTS; k >= 1; k--) begin
            w_cand = ID_WIDTH'((int'(i_last) + k) % N_CLIENTS);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_id    = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_req_ack_arbiter.sv
// N-client round-robin arbiter in front of one shared req/ack target.
// Optional build macro ARB_TIMEOUT_EN adds a target-ack watchdog that
// completes a stuck transaction with cli_err set.
module rr_req_ack_arbiter
    import arb_pkg::*;
#(
    parameter int N_CLIENTS      = ARB_N_CLIENTS,
    parameter int REQ_DATA_WIDTH = ARB_REQ_DATA_W,
    parameter int ACK_DATA_WIDTH = ARB_ACK_DATA_W,
    parameter int ID_WIDTH       = $clog2(N_CLIENTS),
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_CLIENTS-1:0]                i_cli_req,
    input  logic [N_CLIENTS*REQ_DATA_WIDTH-1:0] i_cli_data_req,
    output logic [N_CLIENTS-1:0]                o_cli_ack,
    output logic [ACK_DATA_WIDTH-1:0]           o_cli_data_ack,
    output logic                                o_cli_err,
    output logic                                o_tgt_req,
    output logic [ID_WIDTH+REQ_DATA_WIDTH-1:0]  o_tgt_data_req,
    input  logic                                i_tgt_ack,
    input  logic [ACK_DATA_WIDTH-1:0]           i_tgt_data_ack,
    output logic                                o_busy
);

    // Per-client view of the packed payload bus.
    logic [N_CLIENTS-1:0][REQ_DATA_WIDTH-1:0] w_payload;
    assign w_payload = i_cli_data_req;

    arb_state_t                         r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]                r_id, w_id_nxt;
    logic [ID_WIDTH-1:0]                r_last_winner, w_last_nxt;
    logic                               r_tgt_req, w_tgt_req_nxt;
    logic [ID_WIDTH+REQ_DATA_WIDTH-1:0] r_tgt_data_req, w_tgt_data_nxt;
    logic [N_CLIENTS-1:0]               r_cli_ack, w_cli_ack_nxt;
    logic [ACK_DATA_WIDTH-1:0]          r_cli_data_ack, w_cli_data_nxt;
    logic                               r_cli_err, w_cli_err_nxt;

    logic                               w_pick_vld;
    logic [ID_WIDTH-1:0]                w_pick_id;
    logic                               w_tmo_hit;

    rr_priority_picker #(
        .N_CLIENTS (N_CLIENTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_picker (
        .i_req   (i_cli_req),
        .i_last  (r_last_winner),
        .o_valid (w_pick_vld),
        .o_id    (w_pick_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Watchdog: held at zero outside REQ, counts REQ cycles otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_tmo_cnt <= '0;
        else if (r_state != REQ)   r_tmo_cnt <= '0;
        else                       r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th REQ cycle; a same-cycle ack takes priority.
    assign w_tmo_hit = (r_state == REQ) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;

    // Watchdog absent; the limit is still range-checked so enabling it later is legal.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES must be >= 2");
    end
`endif

    if (N_CLIENTS < 2) begin : g_bad_clients_cfg
        $error("N_CLIENTS must be >= 2");
    end

    // Next-state and next-output logic; ack/data/err are single-cycle pulses.
    always_comb begin
        w_state_nxt    = r_state;
        w_id_nxt       = r_id;
        w_last_nxt     = r_last_winner;
        w_tgt_req_nxt  = r_tgt_req;
        w_tgt_data_nxt = r_tgt_data_req;
        w_cli_ack_nxt  = '0;
        w_cli_data_nxt = '0;
        w_cli_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                // Hold off while the target still shows a stale ack.
                if (w_pick_vld && !i_tgt_ack) begin
                    w_id_nxt       = w_pick_id;
                    w_tgt_data_nxt = {w_pick_id, w_payload[w_pick_id]};
                    w_tgt_req_nxt  = 1'b1;
                    w_state_nxt    = REQ;
                end
            end
            REQ: begin
                if (i_tgt_ack) begin
                    w_tgt_req_nxt  = 1'b0;
                    w_cli_ack_nxt  = N_CLIENTS'(1) << r_id;
                    w_cli_data_nxt = i_tgt_data_ack;
                    w_last_nxt     = r_id;
                    w_state_nxt    = ACK;
                end else if (w_tmo_hit) begin
                    // Timed-out client still moves the pointer so it cannot
                    // monopolise a dead target.
                    w_tgt_req_nxt  = 1'b0;
                    w_cli_ack_nxt  = N_CLIENTS'(1) << r_id;
                    w_cli_err_nxt  = 1'b1;
                    w_last_nxt     = r_id;
                    w_state_nxt    = ACK;
                end
            end
            ACK: begin
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                // Winner must drop its request so the same one is not served twice.
                if (!i_cli_req[r_id] && !i_tgt_ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_id           <= '0;
            r_last_winner  <= ID_WIDTH'(N_CLIENTS - 1);
            r_tgt_req      <= 1'b0;
            r_tgt_data_req <= '0;
            r_cli_ack      <= '0;
            r_cli_data_ack <= '0;
            r_cli_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_id           <= w_id_nxt;
            r_last_winner  <= w_last_nxt;
            r_tgt_req      <= w_tgt_req_nxt;
            r_tgt_data_req <= w_tgt_data_nxt;
            r_cli_ack      <= w_cli_ack_nxt;
            r_cli_data_ack <= w_cli_data_nxt;
            r_cli_err      <= w_cli_err_nxt;
        end
    end

    assign o_cli_ack      = r_cli_ack;
    assign o_cli_data_ack = r_cli_data_ack;
    assign o_cli_err      = r_cli_err;
    assign o_tgt_req      = r_tgt_req;
    assign o_tgt_data_req = r_tgt_data_req;
    assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_rr_req_ack_arbiter.sv
// Scoreboard bench for rr_req_ack_arbiter: stimulus pushes expected grants
// and acks, a negedge monitor pops and compares as the DUT presents them.
module tb_rr_req_ack_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_cli_req = '0;
    logic [31:0] i_cli_data_req = {8'hC3, 8'hA5, 8'h17, 8'h5A};
    logic [3:0]  o_cli_ack;
    logic [7:0]  o_cli_data_ack;
    logic        o_cli_err;
    logic        o_tgt_req;
    logic [9:0]  o_tgt_data_req;
    logic        i_tgt_ack = 1'b0;
    logic [7:0]  i_tgt_data_ack = '0;
    logic        o_busy;

    rr_req_ack_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cli_req      (i_cli_req),
        .i_cli_data_req (i_cli_data_req),
        .o_cli_ack      (o_cli_ack),
        .o_cli_data_ack (o_cli_data_ack),
        .o_cli_err      (o_cli_err),
        .o_tgt_req      (o_tgt_req),
        .o_tgt_data_req (o_tgt_data_req),
        .i_tgt_ack      (i_tgt_ack),
        .i_tgt_data_ack (i_tgt_data_ack),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] ack; logic [7:0] data; logic err; } ack_t;
    typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } dchk_t;

    logic [9:0] exp_grant_q[$];
    ack_t       exp_ack_q[$];
    dchk_t      dchk_q[$];

    int checks = 0;
    int errors = 0;

    // Hand-computed {id, payload} for each client.
    logic [9:0] gtab [4] = '{10'h05A, 10'h117, 10'h2A5, 10'h3C3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.nm = nm; d.act = act; d.exp = exp;
        dchk_q.push_back(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic [9:0] g, input logic [3:0] a,
                              input logic [7:0] d, input logic e);
        ack_t x;
        exp_grant_q.push_back(g);
        x.ack = a; x.data = d; x.err = e;
        exp_ack_q.push_back(x);
    endtask

    task automatic wait_tgt_req();
        int n = 0;
        while (!o_tgt_req && n < 50) begin
            tick();
            n++;
        end
        post("tgt_req_wait", 32'(o_tgt_req), 32'd1);
    endtask

    task automatic pulse_ack(input int dly, input logic [7:0] d);
        repeat (dly) tick();
        i_tgt_ack = 1'b1;
        i_tgt_data_ack = d;
        tick();
        i_tgt_ack = 1'b0;
        i_tgt_data_ack = '0;
    endtask

    // Monitor state
    logic       m_prev_req = 1'b0;
    logic       m_have_fall = 1'b0;
    logic [9:0] m_held = '0;
    int         m_cyc = 0;
    int         m_fall_cyc = 0;
    ack_t       m_x;
    dchk_t      m_d;

    initial begin
        forever begin
            @(negedge clk);
            while (dchk_q.size() > 0) begin
                m_d = dchk_q.pop_front();
                chk(m_d.nm, m_d.act, m_d.exp);
            end
            if (o_tgt_req && !m_prev_req) begin
                if (exp_grant_q.size() == 0)
                    chk("unexpected_tgt_req", 32'(o_tgt_req), 32'd0);
                else
                    chk("tgt_data_req", 32'(o_tgt_data_req), 32'(exp_grant_q.pop_front()));
                if (m_have_fall)
                    chk("idle_gap_ge3", 32'((m_cyc - m_fall_cyc) >= 3), 32'd1);
                m_held = o_tgt_data_req;
            end else if (o_tgt_req) begin
                chk("tgt_data_stable", 32'(o_tgt_data_req), 32'(m_held));
            end
            if (!o_tgt_req && m_prev_req) begin
                m_have_fall = 1'b1;
                m_fall_cyc = m_cyc;
            end
            m_prev_req = o_tgt_req;
            if (o_cli_ack != '0) begin
                if (exp_ack_q.size() == 0) begin
                    chk("unexpected_cli_ack", 32'(o_cli_ack), 32'd0);
                end else begin
                    m_x = exp_ack_q.pop_front();
                    chk("cli_ack", 32'(o_cli_ack), 32'(m_x.ack));
                    chk("cli_data_ack", 32'(o_cli_data_ack), 32'(m_x.data));
                    chk("cli_err", 32'(o_cli_err), 32'(m_x.err));
                end
            end
            m_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int id;
        int n;

        // Reset with every client requesting: outputs all zero.
        i_cli_req = 4'b1111;
        repeat (3) tick();
        post("rst_tgt_req", 32'(o_tgt_req), 32'd0);
        post("rst_tgt_data_req", 32'(o_tgt_data_req), 32'd0);
        post("rst_cli_ack", 32'(o_cli_ack), 32'd0);
        post("rst_cli_data_ack", 32'(o_cli_data_ack), 32'd0);
        post("rst_cli_err", 32'(o_cli_err), 32'd0);
        post("rst_busy", 32'(o_busy), 32'd0);

        // All four requesting: grant order 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            expect_txn(gtab[id], 4'(1 << id), 8'(8'hC0 + k), 1'b0);
            if (k == 0) rst_n = 1'b1;
            wait_tgt_req();
            pulse_ack(1, 8'(8'hC0 + k));
            if (k == 4) i_cli_req = '0;
            else        i_cli_req[id] = 1'b0;
            tick();
            tick();
            if (k < 4) i_cli_req[id] = 1'b1;
        end

        // Single client 2, payload A5, target answers 3C after 3 cycles.
        i_cli_req = '0;
        tick();
        expect_txn(10'h2A5, 4'b0100, 8'h3C, 1'b0);
        i_cli_req = 4'b0100;
        wait_tgt_req();
        post("busy_in_req", 32'(o_busy), 32'd1);
        pulse_ack(3, 8'h3C);
        i_cli_req = '0;
        tick();
        tick();

        // Same client re-requests straight away; monitor checks the idle gap.
        expect_txn(10'h2A5, 4'b0100, 8'h3D, 1'b0);
        i_cli_req = 4'b0100;
        wait_tgt_req();
        pulse_ack(0, 8'h3D);
        i_cli_req = '0;
        tick();
        tick();

        // Client 1 drops its request while in REQ: still acked.
        expect_txn(10'h117, 4'b0010, 8'h66, 1'b0);
        i_cli_req = 4'b0010;
        wait_tgt_req();
        i_cli_req = '0;
        pulse_ack(2, 8'h66);
        tick();
        tick();
        post("idle_after_release", 32'(o_busy), 32'd0);

        // Reset in the middle of a client-3 transaction: no ack ever appears.
        exp_grant_q.push_back(10'h3C3);
        i_cli_req = 4'b1000;
        wait_tgt_req();
        tick();
        rst_n = 1'b0;
        #1;
        post("midrst_tgt_req", 32'(o_tgt_req), 32'd0);
        post("midrst_busy", 32'(o_busy), 32'd0);
        i_tgt_ack = 1'b1;
        i_tgt_data_ack = 8'hEE;
        repeat (3) tick();
        post("midrst_cli_ack", 32'(o_cli_ack), 32'd0);
        i_tgt_ack = 1'b0;
        i_tgt_data_ack = '0;
        i_cli_req = 4'b1111;
        expect_txn(10'h05A, 4'b0001, 8'h77, 1'b0);
        rst_n = 1'b1;
        wait_tgt_req();
        pulse_ack(1, 8'h77);
        i_cli_req = '0;
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        // Target never answers: ack with err 16 cycles after tgt_req rose.
        expect_txn(10'h117, 4'b0010, 8'h00, 1'b1);
        i_cli_req = 4'b0010;
        wait_tgt_req();
        n = 0;
        while (o_cli_ack == '0 && n < 40) begin
            tick();
            n++;
        end
        post("timeout_latency", 32'(n), 32'd16);
        i_cli_req = '0;
        tick();
        tick();

        // Ack lands on the limit cycle: normal completion, no err.
        expect_txn(10'h2A5, 4'b0100, 8'h99, 1'b0);
        i_cli_req = 4'b0100;
        wait_tgt_req();
        pulse_ack(15, 8'h99);
        i_cli_req = '0;
        tick();
        tick();
`else
        // Without the watchdog, REQ waits as long as the target takes.
        expect_txn(10'h3C3, 4'b1000, 8'h42, 1'b0);
        i_cli_req = 4'b1000;
        wait_tgt_req();
        repeat (20) tick();
        post("noto_tgt_req_held", 32'(o_tgt_req), 32'd1);
        post("noto_busy", 32'(o_busy), 32'd1);
        post("noto_cli_err", 32'(o_cli_err), 32'd0);
        pulse_ack(0, 8'h42);
        i_cli_req = '0;
        tick();
        tick();
`endif

        repeat (3) tick();
        post("grant_q_drained", 32'(exp_grant_q.size()), 32'd0);
        post("ack_q_drained", 32'(exp_ack_q.size()), 32'd0);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
